// File: rtl/vga_fb_reader.sv
// Frame-buffer reader for vga_driver: 160x120x3 image in a single-port sync RAM,
// up-scaled 4x, with a host write port and a clear engine sharing the RAM port.
module vga_fb_reader #(
  parameter int FB_W            = 160,
  parameter int FB_H            = 120,
  parameter int SCALE           = 4,
  parameter int TICKS_PER_PIXEL = 2,
  parameter int AW              = 15
) (
  input  logic          clk_50Mhz,
  input  logic          reset_,
  input  logic          i_fetch,
  input  logic          i_v_sync,
  output logic          o_pixel_r,
  output logic          o_pixel_g,
  output logic          o_pixel_b,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [2:0]    i_wr_data,
  input  logic          i_clear_req,
  input  logic [2:0]    i_clear_color,
  output logic          o_busy,
  output logic          o_clear_done
);

  localparam int NPIX   = FB_W * FB_H;
  localparam int TICKS  = SCALE * TICKS_PER_PIXEL;
  localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int COL_W  = $clog2(FB_W);
  localparam int ROW_W  = $clog2(FB_H);
  localparam int SUB_W  = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(TICKS - 1);
  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(FB_W - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(FB_H - 1);
  localparam logic [SUB_W-1:0]  SUB_MAX   = SUB_W'(SCALE - 1);
  localparam logic [AW-1:0]     LAST_ADDR = AW'(NPIX - 1);
  localparam logic [AW-1:0]     ROW_STEP  = AW'(FB_W);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  state_e             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [AW-1:0]      row_base_q, row_base_d;
  logic [AW-1:0]      caddr_q, caddr_d;
  logic [2:0]         color_q, color_d;
  logic               fetch_q;
  logic               done_q, done_d;
  logic [2:0]         pixel_q;

  logic               line_end;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic               wr_ready;
  logic               clear_we;
  logic               host_we;
  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [2:0]         mem_wdata;

  logic [2:0]         mem [NPIX];

  // A falling edge of i_fetch marks the end of a displayed line.
  assign line_end = fetch_q & ~i_fetch;
  assign rd_en    = i_fetch & (tick_q == '0);
  assign rd_addr  = row_base_q + AW'(col_q);

  // Scan counters; a frame restart overrides every other update.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    tick_d     = tick_q;
    col_d      = col_q;
    sub_d      = sub_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    if (!i_v_sync) begin
      tick_d     = '0;
      col_d      = '0;
      sub_d      = '0;
      row_d      = '0;
      row_base_d = '0;
    end else begin
      if (i_fetch) begin
        if (tick_q == TICK_MAX) begin
          tick_d = '0;
          if (col_q != COL_MAX) col_d = col_q + COL_W'(1);
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end else begin
        tick_d = '0;
        col_d  = '0;
      end
      if (line_end) begin
        if (sub_q == SUB_MAX) begin
          sub_d = '0;
          if (row_q != ROW_MAX) begin
            row_d      = row_q + ROW_W'(1);
            row_base_d = row_base_q + ROW_STEP;
          end
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
    end
  end

  // Clear FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_clear_req) state_d = ST_CLEAR;
      ST_CLEAR: if (!rd_en && (caddr_q == LAST_ADDR)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Clear FSM: outputs and port arbitration (display read > clear > host).
  always_comb begin
    wr_ready  = reset_ & ~rd_en & (state_q == ST_IDLE);
    clear_we  = (state_q == ST_CLEAR) & ~rd_en;
    host_we   = i_wr_valid & wr_ready & (i_wr_addr <= LAST_ADDR);
    done_d    = clear_we & (caddr_q == LAST_ADDR);
    mem_we    = clear_we | host_we;
    mem_waddr = clear_we ? caddr_q : i_wr_addr;
    mem_wdata = clear_we ? color_q : i_wr_data;
  end

  always_comb begin
    caddr_d = caddr_q;
    color_d = color_q;
    if ((state_q == ST_IDLE) && i_clear_req) begin
      caddr_d = '0;
      color_d = i_clear_color;
    end else if (clear_we) begin
      caddr_d = caddr_q + AW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_50Mhz or negedge reset_) begin
    if (!reset_) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      col_q      <= '0;
      sub_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      caddr_q    <= '0;
      color_q    <= '0;
      fetch_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      col_q      <= col_d;
      sub_q      <= sub_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      caddr_q    <= caddr_d;
      color_q    <= color_d;
      fetch_q    <= i_fetch;
      done_q     <= done_d;
    end
  end

  // NOTE: the RAM array has no reset; only the registered read port is cleared.
  always_ff @(posedge clk_50Mhz) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Read data lands directly in the pixel register, which holds between reads.
  always_ff @(posedge clk_50Mhz or negedge reset_) begin
    if (!reset_) begin
      pixel_q <= '0;
    end else if (rd_en) begin
      pixel_q <= mem[rd_addr];
    end
  end

  assign o_pixel_r    = pixel_q[2];
  assign o_pixel_g    = pixel_q[1];
  assign o_pixel_b    = pixel_q[0];
  assign o_wr_ready   = wr_ready;
  assign o_busy       = (state_q == ST_CLEAR);
  assign o_clear_done = done_q;

endmodule

// File: doc/vga_fb_reader.md
# vga_fb_reader

Frame-buffer stage sitting directly upstream of `vga_driver`: holds a 160x120, 3-bit (RGB) image in on-chip synchronous RAM and answers the driver's per-cycle `o_fetch_next_pixel` requests with the correct pixel, up-scaled 4x in both axes to fill 640x480. A host-side write port and a hardware clear engine share the single RAM port with the display reads. Display reads always have priority.

## Interface
- `FB_W`, 160: frame-buffer width in pixels.
- `FB_H`, 120: frame-buffer height in pixels.
- `SCALE`, 4: replication factor, horizontal and vertical.
- `TICKS_PER_PIXEL`, 2: driver clock ticks per displayed pixel.
- `AW`, 15: address width; must satisfy 2^AW >= FB_W*FB_H.

Ports:
- `clk_50Mhz`  in  1  sole clock.
- `reset_`  in  1  reset, asynchronous, active-low.
- `i_fetch`  in  1  driver `o_fetch_next_pixel`.
- `i_v_sync`  in  1  driver `o_v_sync`; low = vertical sync, which restarts the frame.
- `o_pixel_r` / `o_pixel_g` / `o_pixel_b`  out  1 each  to driver `i_pixel_*`.
- `i_wr_valid`  in  1  host write request.
- `o_wr_ready`  out  1  write accepted this cycle when valid & ready.
- `i_wr_addr`  in  AW  linear address, row*FB_W+col.
- `i_wr_data`  in  3  {r,g,b}.
- `i_clear_req`  in  1  single-cycle pulse; fill the whole buffer with `i_clear_color`.
- `i_clear_color`  in  3  sampled in the cycle `i_clear_req` is seen in IDLE.
- `o_busy`  out  1  clear in progress.
- `o_clear_done`  out  1  one-cycle pulse when the clear finishes.

## Operation
- RAM: FB_W*FB_H x 3, one port, synchronous read with 1-cycle latency. Contents are undefined after power-up and are not touched by reset.
- Horizontal counters are `tick` (0..SCALE*TICKS_PER_PIXEL-1 = 0..7) and `col` (0..FB_W-1).
  - Both are held at 0 while `i_fetch` = 0.
  - Each fetch cycle, `tick` increments. On wrap 7->0, `col` increments; `col` saturates at FB_W-1.
- Vertical counters are `sub` (0..SCALE-1), `row` (0..FB_H-1) and `row_base` (=row*FB_W, maintained by adding FB_W; no multiplier).
  - On the falling edge of `i_fetch` (end of line), `sub` increments.
  - On `sub` wrap, `row` increments and `row_base` += FB_W. Both saturate at the last row.
- Frame restart: `i_v_sync` = 0 clears `tick`, `col`, `sub`, `row` and `row_base`. This has priority over every other counter update.
- Display read: `rd_en` = `i_fetch` & (`tick` == 0). Read address = `row_base` + `col`, computed combinationally from the current counter values.
- Pixel outputs: RAM read data is registered into a 3-bit pixel register, which holds between reads.
- Port arbitration (priority order): display read, then clear write, then host write.
  - `o_wr_ready` = ~`rd_en` & (state == IDLE).
  - Host writes with `i_wr_addr` >= FB_W*FB_H are accepted and discarded.
- Clear FSM:
  - IDLE: `i_clear_req` goes to CLEAR; capture the color, set `caddr` = 0.
  - CLEAR: on each cycle with ~`rd_en`, write `caddr` and increment it.
    - After writing FB_W*FB_H-1, go to IDLE and pulse `o_clear_done`.
    - `i_clear_req` while in CLEAR is ignored.
- `o_busy` = (state == CLEAR).

## Timing
- Reset values:
  - `o_pixel_*` = 0, `o_busy` = 0, `o_clear_done` = 0.
  - All counters = 0, state = IDLE.
  - `o_wr_ready` = 0 while `reset_` is low; it is 1 in the first cycle after release if `i_fetch` = 0.
- Read latency:
  - Fetch cycle n (0-based within a line) with n%8 == 0 reads `col` = n/8.
  - `o_pixel_*` shows that pixel from cycle n+1 and holds it through cycle n+8.
  - This matches the driver capturing input in the cycle after each fetch.
- Write latency: an accepted host or clear write is visible to a display read issued on the next cycle or later.
- Worst-case host wait is 1 cycle during active video (a read occupies 1 of every 8 cycles), or the full clear duration.
- Clear duration: 19200 free cycles. During active lines, 7 of every 8 cycles are free.
- Reset mid-clear aborts the clear. The buffer is left partially filled and no `o_clear_done` pulse is produced.
- Lines beyond 480 in a frame repeat row 119. Fetch runs longer than 1280 cycles repeat column 159.

## Test plan
- **Host write then display:**
  - Stimulus: write addr 0 = 3'b100 and addr 159 = 3'b001; drive a 1280-cycle fetch run with `i_v_sync` high.
  - Required response: `o_pixel` = 100 for cycles 1..8 and 001 for cycles 1273..1280.
- **Vertical scaling:**
  - Stimulus: write row 1, col 0 (addr 160) = 3'b010; drive 8 fetch runs after a `i_v_sync` low pulse.
  - Required response: lines 0-3 show addr 0; lines 4-7 show 010 in their first pixel.
- **Arbitration:**
  - Stimulus: hold `i_wr_valid` during a fetch run.
  - Required response: `o_wr_ready` = 0 exactly on cycles 0, 8, 16, ... and 1 otherwise. Exactly one write is accepted per ready cycle.
- **Clear:**
  - Stimulus: `i_clear_req` with color 3'b111 while `i_fetch` = 0.
  - Required response: `o_busy` high for 19200 cycles, one `o_clear_done` pulse, then every display read returns 111.
  - With fetch runs active, `o_busy` stays high proportionally longer and no pixel corruption occurs.
- **Out-of-range and frame restart:**
  - Stimulus: write addr 19200, then drive `i_v_sync` low in the middle of a frame.
  - Required response: the write is accepted and RAM is unchanged. The counters restart and the next fetch reads addr 0.
- **Async reset mid-clear:**
  - Stimulus: assert `reset_` low mid-clear.
  - Required response: outputs go to 0 immediately and `o_clear_done` never pulses.
